// File: rtl/tensor_pkg.sv
// Shared types and default sizing for the sequential tensor core.
package tensor_pkg;

  typedef enum logic [1:0] {
    TC_IDLE,
    TC_COMPUTE,
    TC_DONE
  } tc_state_t;

  localparam int TC_N      = 4;
  localparam int TC_DATA_W = 8;
  localparam int TC_OUT_W  = 8;

  // Accumulator width that holds a full N-term sum of DATA_W x DATA_W products.
  function automatic int tc_acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/tensor_mac_cell.sv
// One multiply-accumulate element of the result matrix.
module tensor_mac_cell #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Accumulator: clear has priority over the enabled MAC step; wraps mod 2^ACC_W.
  always_ff @(posedge clk) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/tensor_core_seq.sv
// Sequential N x N matrix multiply: one rank-1 update per cycle over N*N MAC cells.
module tensor_core_seq
  import tensor_pkg::*;
#(
  parameter int N        = TC_N,
  parameter int DATA_W   = TC_DATA_W,
  parameter int ACC_W    = tc_acc_w(N, DATA_W),
  parameter int OUT_W    = TC_OUT_W,
  parameter int SATURATE = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 acc_mode,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      mat_a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]      mat_b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N-1:0][N-1:0][OUT_W-1:0]       mat_c,
  output logic                                 busy
);

  localparam int            KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  tc_state_t                          state;
  logic [KW-1:0]                      k;
  logic [N-1:0][N-1:0][DATA_W-1:0]    a_q, b_q;
  logic [N-1:0][DATA_W-1:0]           a_col, b_row;
  logic [N-1:0][N-1:0][ACC_W-1:0]     acc;
  logic [N-1:0][N-1:0][OUT_W-1:0]     c_nxt;
  logic                               hs, clr, en;

  // in_ready is only high in IDLE, so this is the IDLE-state accept.
  assign hs  = in_valid && in_ready;
  assign clr = hs && !acc_mode;
  assign en  = (state == TC_COMPUTE);

  // Operand capture on accept; held for the whole computation.
  always_ff @(posedge clk) begin
    if (hs) begin
      a_q <= mat_a;
      b_q <= mat_b;
    end
  end

  // Column k of A and row k of B feed the current rank-1 update.
  for (genvar i = 0; i < N; i++) begin : g_mux
    assign a_col[i] = a_q[i][k];
    assign b_row[i] = b_q[k][i];
  end

  // MAC array plus output mapping of the value each cell holds after the final step.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [2*DATA_W-1:0] prod;
      logic [ACC_W-1:0]    fin;

      tensor_mac_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .a     (a_col[i]),
        .b     (b_row[j]),
        .acc   (acc[i][j])
      );

      // mat_c is loaded on the same edge as the last MAC step, so form that sum here.
      assign prod = {{DATA_W{1'b0}}, a_col[i]} * {{DATA_W{1'b0}}, b_row[j]};
      assign fin  = acc[i][j] + ACC_W'(prod);

      if (SATURATE != 0) begin : g_sat
        assign c_nxt[i][j] = (|(fin >> OUT_W)) ? {OUT_W{1'b1}} : fin[OUT_W-1:0];
      end else begin : g_wrap
        assign c_nxt[i][j] = fin[OUT_W-1:0];
      end
    end
  end

  // Control FSM with registered handshake/status outputs and the result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TC_IDLE;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mat_c     <= '0;
    end else begin
      case (state)
        TC_IDLE: begin
          if (hs) begin
            state    <= TC_COMPUTE;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        TC_COMPUTE: begin
          k <= k + 1'b1;
          if (k == K_LAST) begin
            state     <= TC_DONE;
            k         <= '0;
            out_valid <= 1'b1;
            mat_c     <= c_nxt;
          end
        end
        TC_DONE: begin
          if (out_ready) begin
            state     <= TC_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= TC_IDLE;
          k         <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_seq.sv
// Bench for tensor_core_seq: wrap and saturate instances driven in parallel.
module tb_tensor_core_seq;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 8;
  localparam int AW = 2 * DW + $clog2(N);

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  typedef struct {
    string name;
    mat_t  a;
    mat_t  b;
    bit    accm;
    int    hold;
    bit    poke;
    mat_t  exp_w;
    mat_t  exp_s;
  } vec_t;

  logic clk, rst_n, in_valid, acc_mode, out_ready;
  mat_t mat_a, mat_b;
  logic w_in_ready, w_out_valid, w_busy;
  logic s_in_ready, s_out_valid, s_busy;
  logic [N-1:0][N-1:0][OW-1:0] w_mat_c, s_mat_c;

  int checks = 0;
  int errors = 0;

  longint mdl [N][N];

  tensor_core_seq #(.N(N), .DATA_W(DW), .OUT_W(OW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .acc_mode(acc_mode), .mat_a(mat_a), .mat_b(mat_b), .out_valid(w_out_valid),
    .out_ready(out_ready), .mat_c(w_mat_c), .busy(w_busy)
  );

  tensor_core_seq #(.N(N), .DATA_W(DW), .OUT_W(OW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .acc_mode(acc_mode), .mat_a(mat_a), .mat_b(mat_b), .out_valid(s_out_valid),
    .out_ready(out_ready), .mat_c(s_mat_c), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: C = (accm ? C : 0) + sum_k A[i][k]*B[k][j], modulo 2^AW.
  function automatic void mdl_step(input mat_t a, input mat_t b, input bit accm);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s;
        s = accm ? mdl[i][j] : 0;
        for (int kk = 0; kk < N; kk++) s += longint'(a[i][kk]) * longint'(b[kk][j]);
        mdl[i][j] = s % (longint'(1) << AW);
      end
  endfunction

  function automatic mat_t mdl_out(input bit sat);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i][j] = (sat && mdl[i][j] > 255) ? 8'hFF : 8'(mdl[i][j] % 256);
    return r;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = 8'(v);
    return r;
  endfunction

  function automatic mat_t ident();
    mat_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[i][i] = 8'd1;
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // Full transaction: accept, optional busy-time poke, latency, backpressure, release.
  task automatic do_op(input string nm, input mat_t a, input mat_t b, input bit accm,
                       input int hold, input bit poke, input mat_t ew, input mat_t es);
    int n;
    n = 0;
    @(negedge clk);
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready before accept"}, w_in_ready, 1);
    mat_a = a; mat_b = b; acc_mode = accm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " busy/in_ready in compute"}, {w_busy, w_in_ready, s_busy}, 3'b101);
    if (poke) begin
      mat_a = ~a; mat_b = ~b; acc_mode = ~accm; in_valid = 1'b1;
    end
    n = 1;
    while (!w_out_valid && n < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end
    chk({nm, " latency"}, n, N + 1);
    chk({nm, " out_valid sat"}, s_out_valid, 1);
    chk({nm, " mat_c wrap"}, w_mat_c, ew);
    chk({nm, " mat_c sat"}, s_mat_c, es);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold status"}, {w_out_valid, w_in_ready, w_busy}, 3'b101);
      chk({nm, " hold mat_c"}, w_mat_c, ew);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " release status"}, {w_out_valid, w_in_ready, w_busy, s_out_valid}, 4'b0100);
    chk({nm, " mat_c held in idle"}, {w_mat_c, s_mat_c}, {ew, es});
  endtask

  initial begin
    vec_t tbl [4];
    mat_t bseq, onesm;
    int   n;

    rst_n = 1'b0; in_valid = 1'b0; acc_mode = 1'b0; out_ready = 1'b0;
    mat_a = '0; mat_b = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mdl[i][j] = 0;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bseq[i][j] = 8'(4 * i + j);

    tbl[0] = '{"identity",  ident(),    bseq,       1'b0, 0, 1'b0, bseq,    bseq};
    tbl[1] = '{"all255",    fill(255),  fill(255),  1'b0, 1, 1'b0, fill(4), fill(255)};
    tbl[2] = '{"acc_first", ident(),    fill(3),    1'b0, 0, 1'b1, fill(3), fill(3)};
    tbl[3] = '{"acc_add",   ident(),    fill(3),    1'b1, 5, 1'b0, fill(6), fill(6)};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset status", {w_in_ready, w_out_valid, w_busy, s_in_ready, s_out_valid, s_busy},
        6'b100100);
    chk("reset mat_c", {w_mat_c, s_mat_c}, '0);

    for (int v = 0; v < 4; v++) begin
      mdl_step(tbl[v].a, tbl[v].b, tbl[v].accm);
      do_op(tbl[v].name, tbl[v].a, tbl[v].b, tbl[v].accm, tbl[v].hold, tbl[v].poke,
            tbl[v].exp_w, tbl[v].exp_s);
    end

    // Abandon an operation with reset while k=2, then accumulate onto the cleared state.
    @(negedge clk);
    n = 0;
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    mat_a = rand_mat(); mat_b = rand_mat(); acc_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset status", {w_in_ready, w_out_valid, w_busy, s_out_valid}, 4'b1000);
    chk("midreset mat_c", {w_mat_c, s_mat_c}, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mdl[i][j] = 0;
    onesm = fill(1);
    mdl_step(ident(), onesm, 1'b1);
    do_op("after_reset", ident(), onesm, 1'b1, 0, 1'b0, onesm, onesm);

    // Random traffic against the reference model, including accumulate chains.
    for (int r = 0; r < 12; r++) begin
      mat_t ra, rb;
      bit   am;
      ra = rand_mat();
      rb = rand_mat();
      am = 1'($urandom_range(0, 1));
      mdl_step(ra, rb, am);
      do_op($sformatf("rand%0d", r), ra, rb, am, $urandom_range(0, 3),
            1'($urandom_range(0, 1)), mdl_out(1'b0), mdl_out(1'b1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
